alu_issue_ctrl: RTL

//  Initiator-side controller for the combinational ALU. Accepts operation requests over a

---
 rtl/alu_issue_ctrl_if.sv | 50 +++++
 rtl/alu_issue_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request / response / ALU-side bundle for the ALU issue controller.
// Latency: none; this file declares the wires and directions only.
// Backpressure: req_valid/req_ready and rsp_valid/rsp_ready, both consumed at a rising edge.
//
// Ports carried:
//   request  : req_valid, req_ready, req_opcode, req_a, req_b
//   ALU side : alu_a, alu_b, alu_ctrl (to ALU); alu_result, alu_zero, alu_neg (from ALU)
//   response : rsp_valid, rsp_ready, rsp_result, rsp_zero, rsp_neg, rsp_illegal
// Modport slave is the controller. Modport master is the issue logic, which also hosts the ALU.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_opcode;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_neg;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_neg;
    logic              rsp_illegal;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b,
        input  alu_result, alu_zero, alu_neg,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_illegal
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b,
        output alu_result, alu_zero, alu_neg,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_result, rsp_zero, rsp_neg, rsp_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one op to a combinational ALU, holds its inputs while it settles, and captures a held response.
// Latency: the response is valid SETTLE_CYCLES cycles after accept (next cycle for an illegal opcode).
// Backpressure: the response is held until rsp_ready; requests are accepted only in IDLE and are never queued.
//
// Ports:
//   clk, reset_n : clock; synchronous reset, active low
//   bus (slave)  : request handshake, ALU drive/return, response handshake
//   op_count     : responses completed (includes illegal ones); wraps to zero
module alu_issue_ctrl #(
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    alu_issue_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_CMP   = 3'd3;
    localparam logic [2:0] OP_SLL   = 3'd4;
    localparam logic [2:0] OP_SLR   = 3'd5;
    // The ALU default path; driven whenever no operation owns the ALU.
    localparam logic [2:0] CTRL_IDLE   = 3'b111;
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]        settle_cnt;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [2:0]        alu_ctrl_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;
    logic              rsp_neg_q;
    logic              rsp_illegal_q;
    logic              req_ready_c;
    logic              rsp_valid_c;

    logic req_legal;
    logic req_shift;
    assign req_legal = (bus.req_opcode <= OP_SLR);
    assign req_shift = (bus.req_opcode == OP_SLL) || (bus.req_opcode == OP_SLR);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    // Illegal opcodes never touch the ALU and respond at once.
                    state_nxt = req_legal ? SETTLE : RESP;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            settle_cnt    <= 4'd0;
            op_q          <= 3'd0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= CTRL_IDLE;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_neg_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
            op_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= bus.req_opcode;
                        if (req_legal) begin
                            alu_a_q    <= bus.req_a;
                            // Shift distance is the low five bits only, so the ALU never
                            // sees an out-of-range shift amount.
                            alu_b_q    <= req_shift ? {{(DATA_W-5){1'b0}}, bus.req_b[4:0]}
                                                    : bus.req_b;
                            alu_ctrl_q <= bus.req_opcode;
                            settle_cnt <= SETTLE_INIT;
                        end else begin
                            rsp_result_q  <= '0;
                            rsp_zero_q    <= 1'b0;
                            rsp_neg_q     <= 1'b0;
                            rsp_illegal_q <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        rsp_result_q  <= bus.alu_result;
                        // The ALU drives its flags for every op; keep only the ones that
                        // mean something for this opcode.
                        rsp_zero_q    <= (op_q == OP_CMP) && bus.alu_zero;
                        rsp_neg_q     <= ((op_q == OP_ADD) || (op_q == OP_SUB)) && bus.alu_neg;
                        rsp_illegal_q <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        alu_ctrl_q <= CTRL_IDLE;
                        op_count   <= op_count + CNT_W'(1);
                    end
                end
                default: begin
                    alu_ctrl_q <= CTRL_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_ctrl    = alu_ctrl_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_neg     = rsp_neg_q;
    assign bus.rsp_illegal = rsp_illegal_q;

    // OP_AND is listed for decode completeness; opcode 0 passes straight through as ALU control.
    logic unused_and;
    assign unused_and = (OP_AND == 3'd0);
endmodule
